fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter W_CPU, default 32: datapath and PC width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: PC loaded on reset; bits [1:0] SHALL be 0.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 redir_valid  in  1  redirect request this cycle.
REQ-007 redir_src  in  2  redirect type: 0 none, 1 jump, 2 branch, 3 register.
REQ-008 redir_base  in  W_CPU  PC of the redirecting instruction.
REQ-009 jump_addr  in  26  jump target field.
REQ-010 imm_addr  in  16  signed branch word offset.
REQ-011 reg_addr  in  W_CPU  register jump target.
REQ-012 imem_req  out  1  instruction memory request.
REQ-013 imem_addr  out  W_CPU  request address.
REQ-014 imem_gnt  in  1  request accepted when imem_req and imem_gnt are both 1.
REQ-015 imem_rdata  in  32  instruction, valid exactly one cycle after the grant.
REQ-016 out_valid  out  1  queue head valid.
REQ-017 out_ready  in  1  consumer accepts head when out_valid and out_ready are both 1.
REQ-018 out_instr  out  32  head instruction.
REQ-019 out_pc  out  W_CPU  head PC.
REQ-020 count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-021 fetch_pc register: drives imem_addr; advances by 4, modulo 2^W_CPU, on each grant.
REQ-022 imem_req SHALL be 1 only when count + inflight + grant_this_cycle_pending < DEPTH, with no redirect in the same cycle; inflight is 0 or 1.
REQ-023 Response: in the cycle after a grant, {addr, imem_rdata} is pushed to the queue tail, unless it was killed.
REQ-024 Queue: FIFO in order, circular pointers wrapping at DEPTH; push and pop in the same cycle leave count unchanged.
REQ-025 Push never occurs when full, by the rule in REQ-022; pop is ignored when the queue is empty.
REQ-026 out_instr and out_pc SHALL hold the head entry whenever out_valid=1; their values are don't-care when out_valid=0.
REQ-027 Redirect takes effect when redir_valid=1 and redir_src!=0; redir_src=0 is treated as no redirect.
REQ-028 Jump target: {p[W_CPU-1:28], jump_addr, 2'b00}, where p = redir_base+4.
REQ-029 Branch target: redir_base + 4 + (sign-extended imm_addr << 2), modulo 2^W_CPU.
REQ-030 Register target: reg_addr with bits [1:0] forced to 00.
REQ-031 On redirect, next cycle: fetch_pc = target; queue emptied (count=0, out_valid=0); any in-flight response killed and never pushed.
REQ-032 On redirect, imem_req SHALL be 0 in the redirect cycle.
REQ-033 Redirect plus pop in the same cycle: the pop is consumed, the redirect wins, and the queue is empty next cycle.
REQ-034 Redirect plus a response arriving in the same cycle: the response is discarded.
REQ-035 Back-to-back redirects: the last one wins.
REQ-036 Steady state with out_ready=1 and imem_gnt=1: one instruction per cycle; first out_valid two cycles after reset deasserts.

Reset
REQ-037 While rst=1: fetch_pc=RESET_PC, count=0, out_valid=0, imem_req=0, inflight=0, and pending responses are killed.
REQ-038 Reset asserted mid-operation SHALL override redirect, push and pop in that cycle.
REQ-039 First request issues the cycle after rst deasserts, at imem_addr=RESET_PC.

Verification
REQ-040 Reset, then gnt=1 and ready=1 held -> imem_addr 0,4,8,...; out_pc 0,4,8... starting two cycles after reset.
REQ-041 ready=0, gnt=1, DEPTH=4 -> count reaches 4 and imem_req drops; one pop -> exactly one new request is issued.
REQ-042 Branch redirect with base=0x100, imm=0xFFFE -> next imem_addr 0xFC; in-flight response is dropped and out_valid is 0 for one cycle.
REQ-043 Jump redirect with base=0xF0000010, jump_addr=0x0000040 -> target 0xF0000100.
REQ-044 Register redirect with reg_addr=0x203 -> target 0x200; also fire redirect and pop in the same cycle -> count=0 next cycle.
REQ-045 W_CPU=32, fetch_pc=0xFFFFFFFC granted -> next address 0x00000000; rst asserted with a full queue -> count=0 next cycle.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: redirect inputs, instruction memory port, consumer port.
// master = the fetch unit, slave = its environment (core + instruction memory).
interface fetch_queue_if #(
    parameter int unsigned W_CPU = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             redir_valid;
    logic [1:0]       redir_src;
    logic [W_CPU-1:0] redir_base;
    logic [25:0]      jump_addr;
    logic [15:0]      imm_addr;
    logic [W_CPU-1:0] reg_addr;

    logic             imem_req;
    logic [W_CPU-1:0] imem_addr;
    logic             imem_gnt;
    logic [31:0]      imem_rdata;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [W_CPU-1:0] out_pc;
    logic [CW-1:0]    count;

    modport master (
        input  redir_valid, redir_src, redir_base, jump_addr, imm_addr, reg_addr,
        input  imem_gnt, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count
    );

    modport slave (
        output redir_valid, redir_src, redir_base, jump_addr, imm_addr, reg_addr,
        output imem_gnt, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch with at most one response in
// flight, a small FIFO of {pc, instr}, and jump/branch/register redirects that
// flush the queue and kill the outstanding response.
module fetch_queue #(
    parameter int unsigned     W_CPU    = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [W_CPU-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [W_CPU-1:0] PC_STEP    = W_CPU'(4);
    localparam logic [W_CPU-1:0] JUMP_MASK  = {{(W_CPU-28){1'b1}}, 28'h0};
    localparam logic [W_CPU-1:0] ALIGN_MASK = ~W_CPU'(3);

    logic [W_CPU-1:0] fetch_pc_q;
    logic [W_CPU-1:0] resp_pc_q;
    logic             inflight_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    logic [W_CPU-1:0] pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic             redir_c;
    logic [W_CPU-1:0] seq_pc_c;
    logic [W_CPU-1:0] target_c;
    logic             req_c;
    logic             grant_c;
    logic             push_c;
    logic             pop_c;

    // Redirect decode and target selection
    always_comb begin
        redir_c  = bus.redir_valid && (bus.redir_src != 2'd0);
        seq_pc_c = bus.redir_base + PC_STEP;
        target_c = fetch_pc_q;
        case (bus.redir_src)
            2'd1:    target_c = (seq_pc_c & JUMP_MASK) | (W_CPU'(bus.jump_addr) << 2);
            2'd2:    target_c = seq_pc_c
                              + ({{(W_CPU-16){bus.imm_addr[15]}}, bus.imm_addr} << 2);
            2'd3:    target_c = bus.reg_addr & ALIGN_MASK;
            default: target_c = fetch_pc_q;
        endcase
    end

    // Request only when the queue can absorb every outstanding response
    always_comb begin
        req_c   = 1'b0;
        grant_c = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        if (!rst && !redir_c) begin
            req_c  = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
            push_c = inflight_q;
            pop_c  = (count_q != '0) && bus.out_ready;
        end
        grant_c = req_c && bus.imem_gnt;
    end

    // Fetch PC, in-flight tracking and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redir_c) begin
            fetch_pc_q <= target_c;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= grant_c;
            if (grant_c) begin
                fetch_pc_q <= fetch_pc_q + PC_STEP;
                resp_pc_q  <= fetch_pc_q;
            end
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Queue storage: capture the response alongside the address it was fetched from
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = pc_mem[rd_ptr_q];
    assign bus.out_instr = instr_mem[rd_ptr_q];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vectors with literal expectations plus a
// queue-based reference model compared every cycle.
module tb_fetch_queue;
    localparam int unsigned W_CPU = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if #(.W_CPU(W_CPU), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.W_CPU(W_CPU), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] src, input logic [31:0] base,
                                                 input logic [25:0] ja, input logic [15:0] imm,
                                                 input logic [31:0] ra);
        int off;
        off = int'($signed(imm)) * 4;
        case (src)
            2'd1:    return ((base + 32'd4) & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
            2'd2:    return base + 32'd4 + 32'(off);
            2'd3:    return ra & 32'hFFFF_FFFC;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.redir_valid = 1'b0;
        bus.redir_src   = 2'd0;
        bus.redir_base  = 32'h0;
        bus.jump_addr   = 26'h0;
        bus.imm_addr    = 16'h0;
        bus.reg_addr    = 32'h0;
    endtask

    task automatic redirect(input logic [1:0] src, input logic [31:0] base, input logic [25:0] ja,
                            input logic [15:0] imm, input logic [31:0] ra);
        bus.redir_valid = 1'b1;
        bus.redir_src   = src;
        bus.redir_base  = base;
        bus.jump_addr   = ja;
        bus.imm_addr    = imm;
        bus.reg_addr    = ra;
    endtask

    // Instruction memory: data for a granted address appears during the next cycle
    initial begin
        logic        g;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #3;
            g = bus.imem_req && bus.imem_gnt;
            a = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rdata = g ? instr_of(a) : 32'hDEAD_BEEF;
        end
    end

    // Reference model: sequential PC, one outstanding response, FIFO of fetched PCs
    initial begin
        logic [31:0] m_q[$];
        logic [31:0] m_pc;
        logic [31:0] m_inf_pc;
        bit          m_inf;
        bit          known;
        bit          redir;
        bit          exp_req;
        m_pc = 32'h0; m_inf_pc = 32'h0; m_inf = 1'b0; known = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            redir   = bus.redir_valid && (bus.redir_src != 2'd0);
            exp_req = !rst && !redir && ((m_q.size() + int'(m_inf)) < DEPTH);
            if (known) begin
                chk("m_imem_req", 32'(bus.imem_req), 32'(exp_req));
                chk("m_imem_addr", bus.imem_addr, m_pc);
                chk("m_count", 32'(bus.count), 32'(m_q.size()));
                chk("m_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) begin
                    chk("m_out_pc", bus.out_pc, m_q[0]);
                    chk("m_out_instr", bus.out_instr, instr_of(m_q[0]));
                end
            end
            if (rst) begin
                m_pc = 32'h0; m_q.delete(); m_inf = 1'b0; known = 1'b1;
            end else if (redir) begin
                m_pc = model_target(bus.redir_src, bus.redir_base, bus.jump_addr,
                                    bus.imm_addr, bus.reg_addr);
                m_q.delete();
                m_inf = 1'b0;
            end else begin
                if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
                if (m_inf) m_q.push_back(m_inf_pc);
                m_inf    = exp_req && bus.imem_gnt;
                m_inf_pc = m_pc;
                if (m_inf) m_pc = m_pc + 32'd4;
            end
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        rst = 1'b1;
        idle();
        bus.imem_gnt   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);

        // streaming after reset
        @(negedge clk); rst = 1'b0; bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
        #3; chk("first_req", 32'(bus.imem_req), 32'd1); chk("first_addr", bus.imem_addr, 32'h0);
        @(negedge clk); #3; chk("second_addr", bus.imem_addr, 32'h4);
        chk("no_valid_yet", 32'(bus.out_valid), 32'd0);
        @(negedge clk); #3; chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_pc", bus.out_pc, 32'h0);
        @(negedge clk); #3; chk("second_pc", bus.out_pc, 32'h4);
        repeat (3) @(negedge clk);

        // backpressure fills the queue
        @(negedge clk); bus.out_ready = 1'b0;
        repeat (7) @(negedge clk);
        #3; chk("full_count", 32'(bus.count), 32'd4); chk("full_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk); bus.out_ready = 1'b1;
        @(negedge clk); bus.out_ready = 1'b0;
        #3; chk("refill_req", 32'(bus.imem_req), 32'd1); chk("refill_count", 32'(bus.count), 32'd3);
        @(negedge clk); #3; chk("refill_hold", 32'(bus.imem_req), 32'd0);
        @(negedge clk); #3; chk("refill_full", 32'(bus.count), 32'd4);
        chk("refill_hold2", 32'(bus.imem_req), 32'd0);

        // branch redirect with an in-flight response
        @(negedge clk); bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect(2'd2, 32'h100, 26'h0, 16'hFFFE, 32'h0);
        #3; chk("redir_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk); idle();
        #3; chk("br_addr", bus.imem_addr, 32'hFC); chk("br_flush", 32'(bus.out_valid), 32'd0);
        @(negedge clk); #3; chk("br_gap", 32'(bus.out_valid), 32'd0);
        @(negedge clk); #3; chk("br_pc", bus.out_pc, 32'hFC);
        chk("br_instr", bus.out_instr, instr_of(32'hFC));

        // jump redirect
        @(negedge clk); redirect(2'd1, 32'hF000_0010, 26'h40, 16'h0, 32'h0);
        @(negedge clk); idle();
        #3; chk("jmp_addr", bus.imem_addr, 32'hF000_0100);

        // register redirect together with a pop
        @(negedge clk); bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b1;
        redirect(2'd3, 32'h0, 26'h0, 16'h0, 32'h203);
        @(negedge clk); idle(); bus.out_ready = 1'b0;
        #3; chk("reg_addr", bus.imem_addr, 32'h200); chk("reg_count", 32'(bus.count), 32'd0);

        // redir_src = 0 is not a redirect
        @(negedge clk); redirect(2'd0, 32'h800, 26'h0, 16'h0, 32'h0); bus.out_ready = 1'b1;
        #3; chk("src0_req", 32'(bus.imem_req), 32'd1); chk("src0_addr", bus.imem_addr, 32'h204);
        @(negedge clk); idle();
        #3; chk("src0_next", bus.imem_addr, 32'h208);

        // back-to-back redirects: the last one wins
        @(negedge clk); redirect(2'd2, 32'h1000, 26'h0, 16'h0010, 32'h0);
        @(negedge clk); redirect(2'd3, 32'h0, 26'h0, 16'h0, 32'h400);
        #3; chk("b2b_first", bus.imem_addr, 32'h1044);
        @(negedge clk); idle();
        #3; chk("b2b_last", bus.imem_addr, 32'h400);

        // PC wraps modulo 2^32
        @(negedge clk); redirect(2'd3, 32'h0, 26'h0, 16'h0, 32'hFFFF_FFFC);
        @(negedge clk); idle();
        #3; chk("wrap_hi", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #3; chk("wrap_lo", bus.imem_addr, 32'h0);
        @(negedge clk); #3; chk("wrap_pc_hi", bus.out_pc, 32'hFFFF_FFFC);
        @(negedge clk); #3; chk("wrap_pc_lo", bus.out_pc, 32'h0);

        // mixed handshakes and occasional redirects, checked by the model
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.imem_gnt  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                redirect(2'($urandom_range(0, 3)), $urandom, 26'($urandom), 16'($urandom), $urandom);
            else
                idle();
        end

        // reset with a full queue overrides redirect and pop
        @(negedge clk); idle(); bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
        repeat (8) @(negedge clk);
        #3; chk("prerst_full", 32'(bus.count), 32'd4);
        @(negedge clk); rst = 1'b1; bus.out_ready = 1'b1;
        redirect(2'd2, 32'h500, 26'h0, 16'h0, 32'h0);
        #3; chk("rst_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clk); rst = 1'b0; idle();
        #3; chk("rst2_count", 32'(bus.count), 32'd0);
        chk("rst2_addr", bus.imem_addr, 32'h0);
        chk("rst2_req", 32'(bus.imem_req), 32'd1);
        repeat (4) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
